// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and architectural register numbers.
// Used by the register file and the destination register selector.
package mips_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_V0   = 5'd2;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/register_scoreboard.sv
// Pending-write busy bits with set-over-clear priority and two combinational lookups.
// Optional REGISTER_FILE_WRITE_BYPASS_EN: a same-cycle write hides the busy bit it clears.
module register_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pend_set,
  input  logic [ADDR_WIDTH-1:0] pend_reg,
  input  logic                  clear_en,
  input  logic [ADDR_WIDTH-1:0] clear_reg,
  input  logic [ADDR_WIDTH-1:0] read_reg_a,
  input  logic [ADDR_WIDTH-1:0] read_reg_b,
  output logic                  busy_a,
  output logic                  busy_b
);

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_next;

  // Clear first, then set, so a same-edge set on the written register wins.
  always_comb begin
    busy_next = busy;
    if (clear_en) begin
      busy_next[clear_reg] = 1'b0;
    end
    if (pend_set && (pend_reg != ADDR_WIDTH'(REG_ZERO))) begin
      busy_next[pend_reg] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
  logic set_wins;
  logic hide_a;
  logic hide_b;

  // A write in flight to the read register clears it, unless a new pend claims it.
  always_comb begin
    set_wins = pend_set && (pend_reg == clear_reg);
    hide_a   = clear_en && (clear_reg != ADDR_WIDTH'(REG_ZERO))
               && (clear_reg == read_reg_a) && !set_wins;
    hide_b   = clear_en && (clear_reg != ADDR_WIDTH'(REG_ZERO))
               && (clear_reg == read_reg_b) && !set_wins;
  end

  assign busy_a = busy[read_reg_a] && !hide_a;
  assign busy_b = busy[read_reg_b] && !hide_b;
`else
  assign busy_a = busy[read_reg_a];
  assign busy_b = busy[read_reg_b];
`endif

endmodule

// File: rtl/register_file.sv
// 32x32 MIPS GPR file: two combinational reads, one synchronous write, pending-write scoreboard.
// Optional REGISTER_FILE_WRITE_BYPASS_EN forwards write_data to matching reads in the same cycle.
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg_a,
  input  logic [ADDR_WIDTH-1:0] read_reg_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg_rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  pend_set,
  input  logic [ADDR_WIDTH-1:0] pend_reg,
  output logic                  read_busy_a,
  output logic                  read_busy_b,
  output logic [DATA_WIDTH-1:0] register_v0
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] stored_a;
  logic [DATA_WIDTH-1:0] stored_b;
  logic                  write_live;

  assign write_live = write_enable && (write_reg_rd != ADDR_WIDTH'(REG_ZERO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (write_live) begin
      regs[write_reg_rd] <= write_data;
    end
  end

  // $0 reads as zero regardless of storage contents.
  always_comb begin
    stored_a = (read_reg_a == ADDR_WIDTH'(REG_ZERO)) ? '0 : regs[read_reg_a];
    stored_b = (read_reg_b == ADDR_WIDTH'(REG_ZERO)) ? '0 : regs[read_reg_b];
  end

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
  always_comb begin
    read_data_a = (write_live && (write_reg_rd == read_reg_a)) ? write_data : stored_a;
    read_data_b = (write_live && (write_reg_rd == read_reg_b)) ? write_data : stored_b;
    register_v0 = (write_live && (write_reg_rd == ADDR_WIDTH'(REG_V0)))
                  ? write_data : regs[ADDR_WIDTH'(REG_V0)];
  end
`else
  always_comb begin
    read_data_a = stored_a;
    read_data_b = stored_b;
    register_v0 = regs[ADDR_WIDTH'(REG_V0)];
  end
`endif

  register_scoreboard #(
    .REG_COUNT(REG_COUNT)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .pend_set   (pend_set),
    .pend_reg   (pend_reg),
    .clear_en   (write_enable),
    .clear_reg  (write_reg_rd),
    .read_reg_a (read_reg_a),
    .read_reg_b (read_reg_b),
    .busy_a     (read_busy_a),
    .busy_b     (read_busy_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus queues expected values, a negedge monitor compares.
// Honours REGISTER_FILE_WRITE_BYPASS_EN for the same-cycle expectations.
module tb_register_file;

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int SEL_DA = 0;
  localparam int SEL_DB = 1;
  localparam int SEL_BA = 2;
  localparam int SEL_BB = 3;
  localparam int SEL_V0 = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg_a, read_reg_b, write_reg_rd, pend_reg;
  logic [31:0] read_data_a, read_data_b, write_data, register_v0;
  logic        write_enable, pend_set, read_busy_a, read_busy_b;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk          (clk),
    .reset        (reset),
    .read_reg_a   (read_reg_a),
    .read_reg_b   (read_reg_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b),
    .write_enable (write_enable),
    .write_reg_rd (write_reg_rd),
    .write_data   (write_data),
    .pend_set     (pend_set),
    .pend_reg     (pend_reg),
    .read_busy_a  (read_busy_a),
    .read_busy_b  (read_busy_b),
    .register_v0  (register_v0)
  );

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    pend_set     = 1'b0;
  endtask

  // Monitor: every negedge, compare all queued expectations against the live outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        SEL_DA:  act = read_data_a;
        SEL_DB:  act = read_data_b;
        SEL_BA:  act = 32'(read_busy_a);
        SEL_BB:  act = 32'(read_busy_b);
        default: act = register_v0;
      endcase
      compared++;
      if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    reset = 1'b1;
    read_reg_a = '0; read_reg_b = '0;
    write_reg_rd = '0; write_data = '0; pend_reg = '0;
    idle();
    step();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      read_reg_a = 5'(i);
      read_reg_b = 5'(31 - i);
      expect_val($sformatf("rst_da_%0d", i), SEL_DA, 32'h0);
      expect_val($sformatf("rst_db_%0d", 31 - i), SEL_DB, 32'h0);
      expect_val($sformatf("rst_ba_%0d", i), SEL_BA, 32'h0);
      expect_val($sformatf("rst_bb_%0d", 31 - i), SEL_BB, 32'h0);
      if (i == 0) expect_val("rst_v0", SEL_V0, 32'h0);
      step();
    end

    // Write/readback $5 and discarded write to $0
    write_enable = 1'b1; write_reg_rd = 5'd5; write_data = 32'hDEADBEEF; read_reg_a = 5'd5;
    step();
    idle();
    expect_val("wr5_da", SEL_DA, 32'hDEADBEEF);
    step();
    write_enable = 1'b1; write_reg_rd = 5'd0; write_data = 32'h1234; read_reg_b = 5'd0;
    expect_val("wr0_pre_db", SEL_DB, 32'h0);
    step();
    idle();
    expect_val("wr0_db", SEL_DB, 32'h0);
    step();

    // Link register and $v0
    write_enable = 1'b1; write_reg_rd = 5'd31; write_data = 32'h00400008;
    step();
    write_reg_rd = 5'd2; write_data = 32'd7;
    step();
    idle();
    read_reg_b = 5'd31;
    expect_val("ra_db", SEL_DB, 32'h00400008);
    expect_val("v0_7", SEL_V0, 32'd7);
    step();

    // Scoreboard set, then clear by write
    pend_set = 1'b1; pend_reg = 5'd6; read_reg_b = 5'd6;
    expect_val("pend6_pre_bb", SEL_BB, 32'h0);
    step();
    idle();
    expect_val("pend6_bb", SEL_BB, 32'h1);
    step();
    write_enable = 1'b1; write_reg_rd = 5'd6; write_data = 32'h55;
    expect_val("wr6_pre_bb", SEL_BB, BYP ? 32'h0 : 32'h1);
    expect_val("wr6_pre_db", SEL_DB, BYP ? 32'h55 : 32'h0);
    step();
    idle();
    expect_val("wr6_bb", SEL_BB, 32'h0);
    expect_val("wr6_db", SEL_DB, 32'h55);
    step();

    // Same edge, same register: set wins, data still updates
    pend_set = 1'b1; pend_reg = 5'd6;
    write_enable = 1'b1; write_reg_rd = 5'd6; write_data = 32'h66;
    expect_val("both6_pre_bb", SEL_BB, 32'h0);
    step();
    idle();
    expect_val("both6_bb", SEL_BB, 32'h1);
    expect_val("both6_db", SEL_DB, 32'h66);
    step();
    // Re-pend an already busy register, then a single write clears it
    pend_set = 1'b1; pend_reg = 5'd6;
    step();
    idle();
    expect_val("repend6_bb", SEL_BB, 32'h1);
    step();
    write_enable = 1'b1; write_reg_rd = 5'd6; write_data = 32'h77;
    step();
    idle();
    expect_val("clr6_bb", SEL_BB, 32'h0);
    expect_val("clr6_db", SEL_DB, 32'h77);
    step();

    // Same edge, different registers
    pend_set = 1'b1; pend_reg = 5'd8;
    step();
    pend_set = 1'b1; pend_reg = 5'd10;
    write_enable = 1'b1; write_reg_rd = 5'd8; write_data = 32'h88;
    step();
    idle();
    read_reg_a = 5'd8; read_reg_b = 5'd10;
    expect_val("diff8_ba", SEL_BA, 32'h0);
    expect_val("diff10_bb", SEL_BB, 32'h1);
    expect_val("diff8_da", SEL_DA, 32'h88);
    step();

    // pend_set on $0 never marks busy
    pend_set = 1'b1; pend_reg = 5'd0; read_reg_a = 5'd0;
    step();
    idle();
    expect_val("pend0_ba", SEL_BA, 32'h0);
    expect_val("pend0_da", SEL_DA, 32'h0);
    step();

    // Async reset between edges with $9 busy and holding 0xAA
    write_enable = 1'b1; write_reg_rd = 5'd9; write_data = 32'hAA;
    step();
    idle();
    pend_set = 1'b1; pend_reg = 5'd9;
    step();
    idle();
    read_reg_a = 5'd9; read_reg_b = 5'd10;
    expect_val("pre_rst9_da", SEL_DA, 32'hAA);
    expect_val("pre_rst9_ba", SEL_BA, 32'h1);
    step();
    reset = 1'b1;
    expect_val("arst9_da", SEL_DA, 32'h0);
    expect_val("arst9_ba", SEL_BA, 32'h0);
    expect_val("arst10_bb", SEL_BB, 32'h0);
    expect_val("arst_v0", SEL_V0, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Same-cycle forwarding (or its absence) on read port a and $v0
    write_enable = 1'b1; write_reg_rd = 5'd4; write_data = 32'h99; read_reg_a = 5'd4;
    expect_val("byp4_pre_da", SEL_DA, BYP ? 32'h99 : 32'h0);
    step();
    idle();
    expect_val("byp4_da", SEL_DA, 32'h99);
    step();
    write_enable = 1'b1; write_reg_rd = 5'd2; write_data = 32'h22;
    expect_val("bypv0_pre", SEL_V0, BYP ? 32'h22 : 32'h0);
    step();
    idle();
    expect_val("bypv0", SEL_V0, 32'h22);
    step();
    step();

    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      mismatched += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
